taho_input_cond: RTL



---
 rtl/taho_pkg.sv | 25 ++
 rtl/taho_input_cond_if.sv | 24 ++
 rtl/taho_cond_ch.sv | 101 ++++++++++
 rtl/taho_input_cond.sv | 40 ++++
 4 files changed

// File: rtl/taho_pkg.sv
// Shared definitions for the tacho/impulse input conditioner: channel map,
// default filter/stall settings and the per-channel status bundle.
package taho_pkg;

  localparam int CH_TAHO1  = 0;
  localparam int CH_TAHO2  = 1;
  localparam int CH_IMPULS = 2;

  localparam int FILT_LEN_DEF  = 4;
  localparam int STALL_SEC_DEF = 3;

  // Filter counter only has to reach FILT_LEN-1; keep at least one bit.
  function automatic int fcnt_width(input int filt_len);
    int w;
    w = $clog2(filt_len);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic clean;
    logic rise;
    logic stall;
  } ch_stat_t;

endpackage

// File: rtl/taho_input_cond_if.sv
// Bus between the conditioner and its environment: strobes and raw pins in,
// filtered levels, rise strobes, stall flags and glitch counters out.
interface taho_input_cond_if #(
  parameter int NCH    = 3,
  parameter int GCNT_W = 8
);
  logic                  sec;
  logic                  clr_diag;
  logic [NCH-1:0]        pin_raw;
  logic [NCH-1:0]        pin_clean;
  logic [NCH-1:0]        pin_rise;
  logic [NCH-1:0]        stall;
  logic [NCH*GCNT_W-1:0] glitch_cnt;

  modport master (
    output sec, clr_diag, pin_raw,
    input  pin_clean, pin_rise, stall, glitch_cnt
  );

  modport slave (
    input  sec, clr_diag, pin_raw,
    output pin_clean, pin_rise, stall, glitch_cnt
  );
endinterface

// File: rtl/taho_cond_ch.sv
// One conditioner channel: 2-flop synchroniser, persistence filter,
// rising-edge strobe, stall detector and saturating glitch counter.
module taho_cond_ch
  import taho_pkg::*;
#(
  parameter int FILT_LEN  = FILT_LEN_DEF,
  parameter int STALL_SEC = STALL_SEC_DEF,
  parameter int GCNT_W    = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              sec_i,
  input  logic              clr_diag_i,
  input  logic              pin_raw_i,
  output ch_stat_t          stat_o,
  output logic [GCNT_W-1:0] glitch_cnt_o
);

  localparam int FCNT_W = fcnt_width(FILT_LEN);
  localparam int SCNT_W = $clog2(STALL_SEC + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STALL_SEC);
  localparam logic [GCNT_W-1:0] GCNT_MAX  = '1;

  logic              sync1_q, sync2_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              clean_q, clean_d;
  logic              rise_q, rise_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              stall_q, stall_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              glitch;

  // A glitch is the synchronised input falling back to the clean level
  // while a candidate change was still being qualified.
  always_comb begin
    fcnt_d  = fcnt_q;
    clean_d = clean_q;
    glitch  = 1'b0;
    if (sync2_q == clean_q) begin
      glitch = (fcnt_q != '0);
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_LAST) begin
      clean_d = sync2_q;
      fcnt_d  = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign rise_d = clean_d & ~clean_q;

  // An accepted rise takes priority over a coincident seconds strobe.
  always_comb begin
    scnt_d = scnt_q;
    if (rise_d) begin
      scnt_d = '0;
    end else if (sec_i && (scnt_q != SCNT_MAX)) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  assign stall_d = (scnt_d == SCNT_MAX);

  always_comb begin
    gcnt_d = gcnt_q;
    if (clr_diag_i) begin
      gcnt_d = '0;
    end else if (glitch && (gcnt_q != GCNT_MAX)) begin
      gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fcnt_q  <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      scnt_q  <= '0;
      stall_q <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      sync1_q <= pin_raw_i;
      sync2_q <= sync1_q;
      fcnt_q  <= fcnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      scnt_q  <= scnt_d;
      stall_q <= stall_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign stat_o.clean = clean_q;
  assign stat_o.rise  = rise_q;
  assign stat_o.stall = stall_q;
  assign glitch_cnt_o = gcnt_q;

endmodule

// File: rtl/taho_input_cond.sv
// Input conditioner for the tacho/impulse counters: NCH independent channels,
// glitch counters packed with channel i at [i*GCNT_W +: GCNT_W].
module taho_input_cond
  import taho_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int FILT_LEN  = FILT_LEN_DEF,
  parameter int STALL_SEC = STALL_SEC_DEF,
  parameter int GCNT_W    = 8
) (
  input logic               clock,
  input logic               reset,
  taho_input_cond_if.slave  bus
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ch_stat_t          stat;
    logic [GCNT_W-1:0] gcnt;

    taho_cond_ch #(
      .FILT_LEN  (FILT_LEN),
      .STALL_SEC (STALL_SEC),
      .GCNT_W    (GCNT_W)
    ) u_ch (
      .clock_i      (clock),
      .reset_i      (reset),
      .sec_i        (bus.sec),
      .clr_diag_i   (bus.clr_diag),
      .pin_raw_i    (bus.pin_raw[g]),
      .stat_o       (stat),
      .glitch_cnt_o (gcnt)
    );

    assign bus.pin_clean[g]                   = stat.clean;
    assign bus.pin_rise[g]                    = stat.rise;
    assign bus.stall[g]                       = stat.stall;
    assign bus.glitch_cnt[g*GCNT_W +: GCNT_W] = gcnt;
  end

endmodule
